// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush generation and exception/eret/interrupt PC redirect for the 5-stage pipeline.
// Interrupt path (irq, int_en, int_detect) is present only when PIPE_IRQ_EN is defined.
module pipe_ctrl #(
  parameter int                ADDR_W     = 30,
  parameter int                EXP_W      = 3,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_hazard,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic              mem_br_flag,
  input  logic [EXP_W-1:0]  mem_exp_code,
  input  logic              mem_eret,
  input  logic              irq,
  input  logic              int_en_we,
  input  logic              int_en_wd,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic              int_detect,
  output logic              pc_load,
  output logic [ADDR_W-1:0] new_pc,
  output logic [ADDR_W-1:0] epc,
  output logic [EXP_W-1:0]  exp_code,
  output logic              int_en
);

  typedef enum logic [1:0] {RUN = 2'd0, TRAP = 2'd1, RET = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] epc_reg;
  logic [EXP_W-1:0]  exp_code_reg;
  logic              int_en_reg;
  logic              stall;
  logic              accept_ok;
  logic              exc_accept, eret_accept, int_accept, trap_accept;
  logic              event_flush;

  assign stall     = if_busy | mem_busy;
  assign if_stall  = stall | ld_hazard;
  assign id_stall  = stall;
  assign ex_stall  = stall;
  assign mem_stall = stall;

  // Events are only taken in RUN with the pipe moving; a stalled MEM register holds them for later.
  assign accept_ok   = (state_reg == RUN) & ~stall & ~reset;
  assign exc_accept  = accept_ok & mem_en & (mem_exp_code != '0);
  assign eret_accept = accept_ok & mem_en & mem_eret & ~exc_accept;

`ifdef PIPE_IRQ_EN
  logic pre_int_en_reg;

  assign int_accept = accept_ok & mem_en & irq & int_en_reg & ~exc_accept & ~eret_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      int_en_reg     <= 1'b0;
      pre_int_en_reg <= 1'b0;
    end else if (trap_accept) begin
      pre_int_en_reg <= int_en_reg;
      int_en_reg     <= 1'b0;
    end else if (eret_accept) begin
      int_en_reg <= pre_int_en_reg;
    end else if ((state_reg == RUN) && int_en_we) begin
      int_en_reg <= int_en_wd;
    end
  end
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{irq, int_en_we, int_en_wd};
  assign int_accept        = 1'b0;
  assign int_en_reg        = 1'b0;
`endif

  assign trap_accept = exc_accept | int_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (trap_accept) begin
          state_next = TRAP;
        end else if (eret_accept) begin
          state_next = RET;
        end
      end
      TRAP:    state_next = RUN;
      RET:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Redirect cycles are suppressed under reset so a reset in TRAP/RET aborts the PC load.
  always_comb begin
    event_flush = 1'b0;
    pc_load     = 1'b0;
    new_pc      = EXC_VECTOR;
    case (state_reg)
      RUN: begin
        event_flush = trap_accept | eret_accept;
      end
      TRAP: begin
        if (!reset) begin
          event_flush = 1'b1;
          pc_load     = 1'b1;
        end
      end
      RET: begin
        if (!reset) begin
          event_flush = 1'b1;
          pc_load     = 1'b1;
          new_pc      = epc_reg;
        end
      end
      default: begin
        event_flush = 1'b0;
      end
    endcase
  end

  assign if_flush   = event_flush;
  assign id_flush   = event_flush | (ld_hazard & ~reset);
  assign ex_flush   = event_flush;
  assign mem_flush  = event_flush;
  assign int_detect = int_accept;

  // A delay-slot instruction must restart at its branch, one word earlier (wraps modulo 2^ADDR_W).
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_reg      <= '0;
      exp_code_reg <= '0;
    end else if (trap_accept) begin
      epc_reg      <= mem_br_flag ? (mem_pc - ADDR_W'(1)) : mem_pc;
      exp_code_reg <= exc_accept ? mem_exp_code : EXP_W'(1);
    end
  end

  assign epc      = epc_reg;
  assign exp_code = exp_code_reg;
  assign int_en   = int_en_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl; interrupt scenarios run only when PIPE_IRQ_EN is defined.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_busy, mem_busy, ld_hazard, mem_en, mem_br_flag, mem_eret;
  logic [29:0] mem_pc;
  logic [2:0]  mem_exp_code;
  logic        irq, int_en_we, int_en_wd;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        int_detect, pc_load, int_en;
  logic [29:0] new_pc, epc;
  logic [2:0]  exp_code;

  int total = 0;
  int bad   = 0;

  wire [3:0] stalls  = {if_stall, id_stall, ex_stall, mem_stall};
  wire [3:0] flushes = {if_flush, id_flush, ex_flush, mem_flush};

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
    .ld_hazard(ld_hazard), .mem_en(mem_en), .mem_pc(mem_pc),
    .mem_br_flag(mem_br_flag), .mem_exp_code(mem_exp_code), .mem_eret(mem_eret),
    .irq(irq), .int_en_we(int_en_we), .int_en_wd(int_en_wd),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .int_detect(int_detect), .pc_load(pc_load), .new_pc(new_pc),
    .epc(epc), .exp_code(exp_code), .int_en(int_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0; mem_br_flag = 0;
    mem_eret = 0; mem_pc = '0; mem_exp_code = '0; irq = 0; int_en_we = 0; int_en_wd = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; if_busy = 1; ld_hazard = 1; mem_en = 1; mem_exp_code = 3'd3;
    @(negedge clk);
    total++; if (stalls !== 4'b1111) begin bad++; $display("FAIL reset_stalls got=%b exp=1111", stalls); end
    total++; if (flushes !== 4'b0000) begin bad++; $display("FAIL reset_flushes got=%b exp=0000", flushes); end
    total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL reset_pc_load got=%b exp=0", pc_load); end
    tick();
    reset = 0; idle_inputs();
    @(negedge clk);
    total++; if (epc !== 30'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", epc); end
    total++; if (exp_code !== 3'd0) begin bad++; $display("FAIL reset_exp_code got=%0d exp=0", exp_code); end
    total++; if (int_en !== 1'b0) begin bad++; $display("FAIL reset_int_en got=%b exp=0", int_en); end
    total++; if (new_pc !== 30'h0) begin bad++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
    $display("reset: stalls follow inputs, controls forced low, registers cleared");
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs(); ld_hazard = 1;
    @(negedge clk);
    total++; if (stalls !== 4'b1000) begin bad++; $display("FAIL ld_stalls got=%b exp=1000", stalls); end
    total++; if (flushes !== 4'b0100) begin bad++; $display("FAIL ld_flushes got=%b exp=0100", flushes); end
    $display("load_use: if_stall with ID bubble");
    tick(); idle_inputs();
  endtask

  task automatic test_exception();
    idle_inputs(); mem_en = 1; mem_exp_code = 3'd3; mem_pc = 30'h100;
    @(negedge clk);
    total++; if (flushes !== 4'b1111) begin bad++; $display("FAIL exc_accept_flush got=%b exp=1111", flushes); end
    total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL exc_accept_pc_load got=%b exp=0", pc_load); end
    tick(); idle_inputs();
    @(negedge clk);
    total++; if (pc_load !== 1'b1) begin bad++; $display("FAIL exc_trap_pc_load got=%b exp=1", pc_load); end
    total++; if (new_pc !== 30'h0) begin bad++; $display("FAIL exc_trap_new_pc got=%h exp=0", new_pc); end
    total++; if (flushes !== 4'b1111) begin bad++; $display("FAIL exc_trap_flush got=%b exp=1111", flushes); end
    total++; if (epc !== 30'h100) begin bad++; $display("FAIL exc_epc got=%h exp=100", epc); end
    total++; if (exp_code !== 3'd3) begin bad++; $display("FAIL exc_code got=%0d exp=3", exp_code); end
    total++; if (int_en !== 1'b0) begin bad++; $display("FAIL exc_int_en got=%b exp=0", int_en); end
    tick();
    @(negedge clk);
    total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL exc_after_pc_load got=%b exp=0", pc_load); end
    $display("exception: code=3 pc=100 -> TRAP, epc=%h", epc);
    tick();
  endtask

  task automatic test_delay_slot();
    idle_inputs(); mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h0; mem_br_flag = 1;
    tick(); idle_inputs();
    @(negedge clk);
    total++; if (epc !== 30'h3FFFFFFF) begin bad++; $display("FAIL slot_epc got=%h exp=3fffffff", epc); end
    total++; if (exp_code !== 3'd2) begin bad++; $display("FAIL slot_code got=%0d exp=2", exp_code); end
    $display("delay_slot: pc=0 br=1 -> epc=%h", epc);
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs(); mem_en = 1; mem_exp_code = 3'd5; mem_pc = 30'h200;
    tick();
    mem_exp_code = 3'd6; mem_pc = 30'h300;
    @(negedge clk);
    total++; if (pc_load !== 1'b1) begin bad++; $display("FAIL b2b_trap_pc_load got=%b exp=1", pc_load); end
    tick();
    @(negedge clk);
    total++; if (exp_code !== 3'd5) begin bad++; $display("FAIL b2b_trap_ignored got=%0d exp=5", exp_code); end
    total++; if ({pc_load, flushes} !== 5'b01111) begin bad++; $display("FAIL b2b_second_accept got=%b exp=01111", {pc_load, flushes}); end
    tick(); idle_inputs();
    @(negedge clk);
    total++; if ({pc_load, epc} !== {1'b1, 30'h300}) begin bad++; $display("FAIL b2b_second_trap got=%b/%h exp=1/300", pc_load, epc); end
    $display("back_to_back: second exception taken at N+2, exp_code=%0d", exp_code);
    tick();
  endtask

  task automatic test_held_exception();
    idle_inputs(); mem_busy = 1; mem_en = 1; mem_exp_code = 3'd4; mem_pc = 30'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({stalls, flushes, pc_load} !== 9'b1111_0000_0) begin bad++; $display("FAIL held_exc_busy%0d got=%b exp=111100000", i, {stalls, flushes, pc_load}); end
      tick();
    end
    mem_busy = 0;
    @(negedge clk);
    total++; if (flushes !== 4'b1111) begin bad++; $display("FAIL held_exc_accept got=%b exp=1111", flushes); end
    tick(); idle_inputs();
    @(negedge clk);
    total++; if ({pc_load, epc} !== {1'b1, 30'h40}) begin bad++; $display("FAIL held_exc_trap got=%b/%h exp=1/40", pc_load, epc); end
    $display("held_exception: accepted after 3 busy cycles");
    tick();
  endtask

  task automatic test_eret();
    idle_inputs(); mem_en = 1; mem_eret = 1;
    @(negedge clk);
    total++; if (flushes !== 4'b1111) begin bad++; $display("FAIL eret_accept got=%b exp=1111", flushes); end
    tick(); idle_inputs();
    @(negedge clk);
    total++; if ({pc_load, new_pc} !== {1'b1, 30'h40}) begin bad++; $display("FAIL eret_ret got=%b/%h exp=1/40", pc_load, new_pc); end
    total++; if (int_en !== 1'b0) begin bad++; $display("FAIL eret_int_en got=%b exp=0", int_en); end
    $display("eret: RET to epc=%h", new_pc);
    tick();
  endtask

`ifdef PIPE_IRQ_EN
  task automatic test_held_irq();
    idle_inputs(); int_en_we = 1; int_en_wd = 1;
    tick(); idle_inputs();
    @(negedge clk);
    total++; if (int_en !== 1'b1) begin bad++; $display("FAIL irq_int_en_write got=%b exp=1", int_en); end
    irq = 1; mem_en = 1; mem_pc = 30'h55; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({int_detect, flushes} !== 5'b0_0000) begin bad++; $display("FAIL irq_busy%0d got=%b exp=00000", i, {int_detect, flushes}); end
      tick();
    end
    mem_busy = 0;
    @(negedge clk);
    total++; if ({int_detect, flushes} !== 5'b1_1111) begin bad++; $display("FAIL irq_accept got=%b exp=11111", {int_detect, flushes}); end
    tick(); idle_inputs();
    @(negedge clk);
    total++; if ({pc_load, epc, exp_code, int_en} !== {1'b1, 30'h55, 3'd1, 1'b0}) begin bad++; $display("FAIL irq_trap got=%b/%h/%0d/%b exp=1/55/1/0", pc_load, epc, exp_code, int_en); end
    $display("held_irq: interrupt taken after busy, epc=%h", epc);
    tick();
  endtask

  task automatic test_priority();
    idle_inputs(); int_en_we = 1; int_en_wd = 1;
    tick(); idle_inputs();
    mem_en = 1; irq = 1; mem_exp_code = 3'd7; mem_pc = 30'h77;
    @(negedge clk);
    total++; if ({int_detect, flushes} !== 5'b0_1111) begin bad++; $display("FAIL prio_exc got=%b exp=01111", {int_detect, flushes}); end
    tick(); idle_inputs();
    tick();
    total++; if ({exp_code, int_en} !== {3'd7, 1'b0}) begin bad++; $display("FAIL prio_exc_regs got=%0d/%b exp=7/0", exp_code, int_en); end
    mem_en = 1; irq = 1; mem_eret = 1;
    @(negedge clk);
    total++; if ({int_detect, flushes} !== 5'b0_1111) begin bad++; $display("FAIL prio_eret got=%b exp=01111", {int_detect, flushes}); end
    tick(); mem_eret = 0;
    @(negedge clk);
    total++; if ({pc_load, new_pc, int_en, int_detect} !== {1'b1, 30'h77, 1'b1, 1'b0}) begin bad++; $display("FAIL prio_ret got=%b/%h/%b/%b exp=1/77/1/0", pc_load, new_pc, int_en, int_detect); end
    tick();
    @(negedge clk);
    total++; if (int_detect !== 1'b1) begin bad++; $display("FAIL prio_irq_n2 got=%b exp=1", int_detect); end
    tick(); idle_inputs();
    $display("priority: exception over irq, eret over irq, irq at N+2");
    tick();
  endtask
`else
  task automatic test_irq_disabled();
    idle_inputs(); int_en_we = 1; int_en_wd = 1; irq = 1; mem_en = 1;
    @(negedge clk);
    total++; if ({int_detect, flushes} !== 5'b0_0000) begin bad++; $display("FAIL noirq_ignored got=%b exp=00000", {int_detect, flushes}); end
    tick(); idle_inputs();
    @(negedge clk);
    total++; if ({int_en, pc_load} !== 2'b00) begin bad++; $display("FAIL noirq_int_en got=%b exp=00", {int_en, pc_load}); end
    $display("irq_disabled: irq and int_en writes ignored");
    tick();
  endtask
`endif

  task automatic test_reset_in_trap();
    idle_inputs(); mem_en = 1; mem_exp_code = 3'd3; mem_pc = 30'h123;
    tick(); idle_inputs(); reset = 1;
    @(negedge clk);
    total++; if ({pc_load, flushes} !== 5'b0_0000) begin bad++; $display("FAIL rtrap_forced got=%b exp=00000", {pc_load, flushes}); end
    tick(); reset = 0;
    @(negedge clk);
    total++; if ({pc_load, flushes} !== 5'b0_0000) begin bad++; $display("FAIL rtrap_no_redirect got=%b exp=00000", {pc_load, flushes}); end
    total++; if ({epc, int_en} !== {30'h0, 1'b0}) begin bad++; $display("FAIL rtrap_regs got=%h/%b exp=0/0", epc, int_en); end
    $display("reset_in_trap: redirect aborted");
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_load_use();
    test_exception();
    test_delay_slot();
    test_back_to_back();
    test_held_exception();
    test_eret();
`ifdef PIPE_IRQ_EN
    test_held_irq();
    test_priority();
`else
    test_irq_disabled();
`endif
    test_reset_in_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the 5-stage CPU (IF/ID/EX/MEM/WB). It generates the stall and flush controls for every inter-stage pipeline register. It accepts exceptions, interrupts and exception-return from the MEM stage and redirects the PC to the handler vector or the saved return address. It holds the EPC, the exception code and the interrupt-enable status bits.

## Interface
Parameters:
- ADDR_W, 30, word-address width (PC, EPC, vector)
- EXP_W, 3, exception code width; code 0 = no exception
- EXC_VECTOR, 30'h0, handler word address

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_busy  in  1  IF bus access in progress
- mem_busy  in  1  MEM bus access in progress
- ld_hazard  in  1  load-use hazard detected in ID
- mem_en  in  1  MEM-stage instruction valid
- mem_pc  in  ADDR_W  MEM-stage PC
- mem_br_flag  in  1  MEM-stage instruction is in a branch delay slot
- mem_exp_code  in  EXP_W  MEM-stage exception code
- mem_eret  in  1  MEM-stage instruction is exception-return
- irq  in  1  masked, level interrupt request
- int_en_we  in  1  software write of int_en
- int_en_wd  in  1  int_en write data
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold stage register
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  clear stage register (en=0)
- int_detect  out  1  interrupt accepted this cycle
- pc_load  out  1  IF must load new_pc
- new_pc  out  ADDR_W  redirect target
- epc  out  ADDR_W  saved return address
- exp_code  out  EXP_W  last accepted cause
- int_en  out  1  interrupt enable status

## Operation
- stall = if_busy | mem_busy.
- if_stall = stall | ld_hazard.
- id_stall = ex_stall = mem_stall = stall.
- Load-use hazard: id_flush = ld_hazard (bubble into ID/EX), unless an event flush is active.
- Event acceptance happens only in state RUN with stall = 0. Priority is exception > eret > interrupt.
  - Exception: mem_en=1 and mem_exp_code≠0.
  - Eret: mem_en=1 and mem_eret=1.
  - Interrupt: mem_en=1, irq=1, int_en=1.
- Accept cycle N, all events:
  - All four *_flush = 1; ld_hazard bubble is irrelevant.
  - int_detect = 1 for an interrupt only.
- Exception or interrupt accept, registered at the end of N:
  - epc <= mem_br_flag ? mem_pc−1 : mem_pc. Modulo 2^ADDR_W; mem_pc=0 in a delay slot gives all ones.
  - exp_code <= mem_exp_code. An interrupt stores the reserved code 1.
  - pre_int_en <= int_en; int_en <= 0.
  - State -> TRAP.
- Eret accept: int_en <= pre_int_en at the end of N; state -> RET.
- TRAP (1 cycle): pc_load=1, new_pc=EXC_VECTOR, all *_flush=1. Next state RUN.
- RET (1 cycle): pc_load=1, new_pc=epc, all *_flush=1. Next state RUN.
- In TRAP/RET, irq, exceptions and eret are ignored. Stalls still pass through.
- int_en_we updates int_en in RUN only. If it coincides with an accept, the accept's update wins and the write is dropped.
- In all other cycles pc_load=0 and new_pc=EXC_VECTOR.

## Timing
- Stall paths and ld_hazard are combinational, zero latency.
- Event acceptance and the accept-cycle flushes are combinational from MEM-stage inputs, in the same cycle.
- pc_load asserts exactly one cycle after accept. First handler fetch is at N+2.
- Back-to-back events: earliest next accept is N+2.
- An event arriving while stall=1 is held off. It is accepted in the first stall=0 cycle if still presented; inputs are held by the stalled MEM register.
- Reset (sync):
  - Registers: state=RUN, epc=0, exp_code=0, int_en=0, pre_int_en=0.
  - While reset=1: all *_flush, int_detect and pc_load are forced 0; stalls still follow inputs.
- Reset in TRAP/RET aborts the redirect: no pc_load on the following cycle.

## Configuration
- PIPE_IRQ_EN defined:
  - Interrupt path present as above.
- PIPE_IRQ_EN undefined:
  - irq and int_en_we/int_en_wd are ignored.
  - int_en and int_detect are constant 0; pre_int_en is removed.
  - Eret leaves int_en at 0.
  - Exceptions and eret otherwise behave identically.

## Test plan
- Load-use: ld_hazard=1, buses idle -> if_stall=1, id_flush=1, id/ex/mem_stall=0, no flush elsewhere.
- Exception: mem_en=1, mem_exp_code=3, mem_pc=30'h100, br_flag=0, stall=0.
  - Cycle N: all flushes=1.
  - N+1: pc_load=1, new_pc=EXC_VECTOR.
  - After: epc=30'h100, exp_code=3, int_en=0.
- Delay-slot wrap: mem_pc=0, mem_br_flag=1, mem_exp_code=2 -> epc=30'h3FFFFFFF.
- Held interrupt: int_en=1, irq=1, mem_busy=1 for 3 cycles.
  - While busy: stalls only, int_detect=0.
  - First idle cycle: int_detect=1, flushes=1.
  - Next cycle: pc_load=1.
- Priority: exception and irq together -> exception taken, int_detect=0. Eret and irq together -> RET, new_pc=epc, int_en restored, irq taken no earlier than 2 cycles later.
- Reset in TRAP: reset=1 during TRAP -> pc_load=0 next cycle, state RUN, epc=0, int_en=0.
